psa_accum_unit: RTL

- Sequential consumer of the 16-bit parallel sub-word add path: accumulates a stream of 16-bit operands as four independent 4-bit lanes.
- Lane arithmetic is identical to the PSA: per-nibble modulo-16 add; a nibble carry-out flags that lane.
- Used for multi-operand packed reductions in the execute stage; ships the final packed sum plus per-lane sticky carry flags downstream over a valid/ready handshake.

---
 rtl/psa_accum_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/psa_accum_unit.sv
// Multi-operand packed accumulator: sums a stream of 16-bit operands as four
// independent 4-bit lanes and reports per-lane sticky carry flags.
module psa_accum_unit #(
    parameter int NUM_OPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] acc,
    output logic [3:0]  err_lane,
    output logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_OPS - 1);

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  err_q, err_d;
    logic [7:0]  count_q, count_d;
    logic [4:0]  lane_sum_s;

    // Lane add with its carry-out in bit 4; lanes never see each other's carry.
    function automatic logic [4:0] lane_add(input logic [3:0] a, input logic [3:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // State, accumulator, flag and operand-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 16'd0;
            err_q   <= 4'd0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        err_d      = err_q;
        count_d    = count_q;
        lane_sum_s = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = 16'd0;
                    err_d   = 4'd0;
                    count_d = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        lane_sum_s       = lane_add(acc_q[4*i +: 4], in_data[4*i +: 4]);
                        acc_d[4*i +: 4]  = lane_sum_s[3:0];
                        err_d[i]         = err_q[i] | lane_sum_s[4];
                    end
                    count_d = count_q + 8'd1;
                    if (count_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode directly from registered state.
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign acc       = acc_q;
    assign err_lane  = err_q;
    assign error     = |err_q;

endmodule
